serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
- Asynchronous serial byte receiver: start bit, DATA_BITS data bits LSB-first, one stop bit, idle-high line.
- Sits directly downstream of the 3-tap input glitch filter. It consumes the filter's registered, deglitched line bit and delivers bytes over a single-entry valid/ready holding register.
- Reports framing errors and overruns to the consumer logic.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in  in  1  filtered serial line; idle = 1; already synchronous to clk.
- data_out  out  DATA_BITS  received word; bit 0 = first bit on the wire.
- valid  out  1  data_out holds an unconsumed word.
- ready  in  1  consumer accepts data_out when valid && ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  sticky: a good word was dropped because the holding register was full.
- clr_err  in  1  clears overrun.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: data_out=0, valid=0, frame_err=0, overrun=0, busy=0; FSM=IDLE, bit counter=0, timer=0. Reset mid-frame abandons the frame; nothing is delivered.
- Define H = CLKS_PER_BIT/2. The timer is $clog2(CLKS_PER_BIT) bits wide and counts down, reloading on each sample.
- FSM states:
  - IDLE: if in==0 at edge t0, go to START and load timer = H-1.
  - START: when timer==0 (edge t0+H), sample in. If in==1, false start: go to IDLE, no flags. If in==0, go to DATA with bit index 0 and timer = CLKS_PER_BIT-1.
  - DATA: data bit k is sampled at edge t0+H+(k+1)*CLKS_PER_BIT and shifted in LSB-first. After bit DATA_BITS-1, go to STOP.
  - STOP: sample at t0+H+(DATA_BITS+1)*CLKS_PER_BIT.
    - in==1: deliver the word and go to IDLE.
    - in==0: pulse frame_err for 1 cycle, discard the word, go to WAIT_IDLE.
  - WAIT_IDLE: stay until in==1, then go to IDLE. This prevents a break condition (line held low) from retriggering reception.
- Delivery: at the edge after the stop sample, data_out and valid=1 are visible. Latency from start-edge detection is H+(DATA_BITS+1)*CLKS_PER_BIT+1 cycles.
- Holding register handshake:
  - valid && ready at an edge: word consumed, valid=0 next cycle, unless a delivery occurs on the same edge.
  - Delivery while valid=1 and ready=0: keep the old data_out and valid, discard the new word, set overrun=1.
  - Delivery on the same edge as a consume: load the new word, valid stays 1, no overrun.
  - data_out is held stable while valid=1 and not consumed.
- overrun:
  - Cleared by clr_err on the next edge.
  - If clr_err and a new overrun event coincide, the set wins.
- frame_err has no effect on valid or overrun.
- A new start bit may be detected on the cycle after the return to IDLE. Back-to-back frames with a stop bit of exactly CLKS_PER_BIT cycles must be received without loss.

Decomposition:
- Shared include serial_defs.vh holds:
  - FSM state encodings: IDLE, START, DATA, STOP, WAIT_IDLE (3-bit).
  - Default CLKS_PER_BIT and DATA_BITS. The future serial_tx uses the same include.
- One natural sub-module: serial_bit_timer.
  - Loadable down-counter; inputs load and load_val; output tick when the count reaches 0.
  - Reused by serial_tx.
- The shift register, FSM and holding register stay in serial_rx.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8):
- Frame 0xA5 with ready=1 -> data_out=0xA5, valid for 1 cycle, exactly 153 cycles after the start edge is seen. frame_err=0, overrun=0.
- 3-cycle low glitch on an idle line -> no delivery, no flags, FSM returns to IDLE at t0+8.
- Frame 0x3C with stop bit driven 0, then the line held low for 40 bit-times -> one frame_err pulse, valid=0, no second frame detected until in returns to 1.
- Two frames 0x11 then 0x22 with ready=0 -> data_out stays 0x11, valid=1, overrun=1. Then pulse ready -> valid=0. Then clr_err -> overrun=0.
- ready asserted on exactly the delivery edge of the second frame -> 0x11 consumed, data_out=0x22, valid=1, overrun=0.
- rst asserted mid-DATA of frame 0xFF, released, then frame 0x5A sent -> only 0x5A delivered; all outputs 0 in the cycle after rst.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receiver family: FSM encodings, default
// frame geometry and a small timing helper.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Loadable down-counter that flags when it has run out; it parks at zero
// until reloaded, so tick stays high while the count is exhausted.
module serial_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/serial_rx.sv
// Serial byte receiver: start bit, LSB-first data, one stop bit, with a
// single-entry valid/ready holding register and framing/overrun reporting.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_err,
  output logic                 busy
);

  localparam int H  = half_bit(CLKS_PER_BIT);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  rx_state_e            state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver_q, deliver_d;
  logic                 frame_err_q, frame_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic                 tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 tmr_tick;

  serial_bit_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick)
  );

  // Each sample reloads the timer so the next sample lands mid-bit.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      ST_IDLE: begin
        if (!in) begin
          state_d  = ST_START;
          tmr_load = 1'b1;
          tmr_val  = TW'(H - 1);
        end
      end
      ST_START: begin
        if (tmr_tick) begin
          if (in) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            tmr_load  = 1'b1;
            tmr_val   = TW'(CLKS_PER_BIT - 1);
          end
        end
      end
      ST_DATA: begin
        if (tmr_tick) begin
          shift_d  = {in, shift_q[DATA_BITS-1:1]};
          tmr_load = 1'b1;
          tmr_val  = TW'(CLKS_PER_BIT - 1);
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tmr_tick) begin
          if (in) begin
            deliver_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // A held-low break must not look like a fresh start bit.
        if (in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A delivery into a full, unconsumed register is dropped and flagged.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (clr_err) begin
      overrun_d = 1'b0;
    end
    if (deliver_q) begin
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx at 16 clocks per bit, 8 data bits; inputs
// change one time unit after a rising edge and outputs are sampled there.
module tb_serial_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       line_in;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;
  logic       busy;

  int total_checks;
  int passed_checks;
  int err_pulses;

  serial_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (line_in),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Drives start bit plus data bits LSB-first; the caller drives the stop bit.
  task automatic applyStimulus(input logic [7:0] word);
    line_in = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      line_in = word[i];
      waitCycles(CPB);
    end
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    err_pulses    = 0;
    rst     = 1'b1;
    line_in = 1'b1;
    ready   = 1'b0;
    clr_err = 1'b0;
    waitCycles(3);
    checkOutput("reset_data", 16'(data_out), 16'h00);
    checkOutput("reset_valid", 16'(valid), 16'h0);
    checkOutput("reset_frame_err", 16'(frame_err), 16'h0);
    checkOutput("reset_overrun", 16'(overrun), 16'h0);
    checkOutput("reset_busy", 16'(busy), 16'h0);
    rst = 1'b0;
    waitCycles(2);

    $display("[TB] frame 0xA5, ready high");
    ready = 1'b1;
    applyStimulus(8'hA5);
    line_in = 1'b1;
    checkOutput("a5_busy_mid", 16'(busy), 16'h1);
    waitCycles(8);
    checkOutput("a5_valid_t151", 16'(valid), 16'h0);
    waitCycles(1);
    checkOutput("a5_valid_t152", 16'(valid), 16'h0);
    checkOutput("a5_busy_t152", 16'(busy), 16'h0);
    checkOutput("a5_frame_err", 16'(frame_err), 16'h0);
    waitCycles(1);
    checkOutput("a5_valid_t153", 16'(valid), 16'h1);
    checkOutput("a5_data_t153", 16'(data_out), 16'hA5);
    checkOutput("a5_overrun", 16'(overrun), 16'h0);
    waitCycles(1);
    checkOutput("a5_valid_t154", 16'(valid), 16'h0);
    waitCycles(10);

    $display("[TB] 3-cycle glitch");
    line_in = 1'b0;
    waitCycles(3);
    line_in = 1'b1;
    waitCycles(5);
    checkOutput("glitch_busy_t7", 16'(busy), 16'h1);
    waitCycles(1);
    checkOutput("glitch_busy_t8", 16'(busy), 16'h0);
    checkOutput("glitch_valid", 16'(valid), 16'h0);
    checkOutput("glitch_frame_err", 16'(frame_err), 16'h0);
    waitCycles(20);

    $display("[TB] frame 0x3C with bad stop bit, then break");
    applyStimulus(8'h3C);
    line_in = 1'b0;
    waitCycles(8);
    checkOutput("ferr_before", 16'(frame_err), 16'h0);
    waitCycles(1);
    checkOutput("ferr_pulse", 16'(frame_err), 16'h1);
    checkOutput("ferr_busy", 16'(busy), 16'h1);
    waitCycles(1);
    checkOutput("ferr_after", 16'(frame_err), 16'h0);
    checkOutput("ferr_valid", 16'(valid), 16'h0);
    for (int i = 0; i < 40 * CPB; i++) begin
      waitCycles(1);
      if (frame_err) err_pulses++;
    end
    checkOutput("break_no_retrigger", 16'(err_pulses), 16'h0);
    checkOutput("break_busy", 16'(busy), 16'h1);
    checkOutput("break_valid", 16'(valid), 16'h0);
    line_in = 1'b1;
    waitCycles(1);
    checkOutput("break_release_busy", 16'(busy), 16'h0);
    waitCycles(20);

    $display("[TB] overrun: 0x11 then 0x22 with ready low");
    ready = 1'b0;
    applyStimulus(8'h11);
    line_in = 1'b1;
    waitCycles(CPB);
    applyStimulus(8'h22);
    line_in = 1'b1;
    waitCycles(CPB);
    checkOutput("ovr_data", 16'(data_out), 16'h11);
    checkOutput("ovr_valid", 16'(valid), 16'h1);
    checkOutput("ovr_flag", 16'(overrun), 16'h1);
    ready = 1'b1;
    waitCycles(1);
    ready = 1'b0;
    checkOutput("ovr_consumed_valid", 16'(valid), 16'h0);
    checkOutput("ovr_sticky", 16'(overrun), 16'h1);
    clr_err = 1'b1;
    waitCycles(1);
    clr_err = 1'b0;
    checkOutput("ovr_cleared", 16'(overrun), 16'h0);
    waitCycles(5);

    $display("[TB] consume on the delivery edge");
    applyStimulus(8'h11);
    line_in = 1'b1;
    waitCycles(CPB);
    checkOutput("same_first_valid", 16'(valid), 16'h1);
    applyStimulus(8'h22);
    line_in = 1'b1;
    waitCycles(9);
    checkOutput("same_pre_data", 16'(data_out), 16'h11);
    ready = 1'b1;
    waitCycles(1);
    ready = 1'b0;
    checkOutput("same_data", 16'(data_out), 16'h22);
    checkOutput("same_valid", 16'(valid), 16'h1);
    checkOutput("same_overrun", 16'(overrun), 16'h0);
    waitCycles(1);
    checkOutput("same_hold_data", 16'(data_out), 16'h22);
    checkOutput("same_hold_valid", 16'(valid), 16'h1);
    waitCycles(10);

    $display("[TB] reset mid-frame 0xFF, then 0x5A");
    line_in = 1'b0;
    waitCycles(CPB);
    line_in = 1'b1;
    waitCycles(40);
    checkOutput("rst_mid_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("rst_mid_data", 16'(data_out), 16'h00);
    checkOutput("rst_mid_valid", 16'(valid), 16'h0);
    checkOutput("rst_mid_frame_err", 16'(frame_err), 16'h0);
    checkOutput("rst_mid_overrun", 16'(overrun), 16'h0);
    checkOutput("rst_mid_busy_clr", 16'(busy), 16'h0);
    rst = 1'b0;
    waitCycles(200);
    checkOutput("rst_no_delivery", 16'(valid), 16'h0);
    applyStimulus(8'h5A);
    line_in = 1'b1;
    waitCycles(CPB);
    checkOutput("post_rst_data", 16'(data_out), 16'h5A);
    checkOutput("post_rst_valid", 16'(valid), 16'h1);
    ready = 1'b1;
    waitCycles(1);
    ready = 1'b0;
    checkOutput("post_rst_consumed", 16'(valid), 16'h0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
